// File: rtl/c_tick_gen.sv
// c_tick_gen: switch-driven speed select and single-cycle TICK enable for the
// LED chaser. Everything runs on CLOCK; the chaser advances on CLOCK when TICK=1,
// so no derived or gated clocks are needed downstream.
module c_tick_gen #(
  parameter int unsigned DIV_SLOW   = 270_270_270,
  parameter int unsigned DIV_MED    = 66_666_667,
  parameter int unsigned DIV_FAST   = 16_666_667,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 29
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  output logic       TICK,
  output logic [1:0] SPEED,
  output logic [2:0] SW_DB
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] LAST_MED  = CNT_W'(DIV_MED - 1);
  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(DIV_FAST - 1);

  logic [2:0]       sw_raw;
  logic [2:0]       sw_db_w;
  logic [1:0]       speed_reg;
  logic [1:0]       speed_next;
  logic [CNT_W-1:0] div_cnt_reg;
  logic [CNT_W-1:0] div_last;
  logic             tick_reg;
  logic             run;

  assign sw_raw = {SW2, SW1, SW0};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sw
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_reg;
      logic [DEB_W-1:0] deb_cnt_reg;

      // Two-flop synchroniser for the raw, asynchronous switch input.
      always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= sw_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Accept a new level only after it has differed from the held level for DEB_CYCLES edges.
      always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
          db_reg      <= 1'b0;
          deb_cnt_reg <= '0;
        end else if (sync2_reg != db_reg) begin
          if (deb_cnt_reg == DEB_LAST) begin
            db_reg      <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
          end
        end else begin
          deb_cnt_reg <= '0;
        end
      end

      assign sw_db_w[gi] = db_reg;
    end
  endgenerate

  // Priority select: the highest debounced switch sets the rate.
  always_comb begin
    speed_next = 2'd0;
    if (sw_db_w[2])      speed_next = 2'd3;
    else if (sw_db_w[1]) speed_next = 2'd2;
    else if (sw_db_w[0]) speed_next = 2'd1;
  end

  // Terminal count for the rate being loaded this edge, so a rate change takes effect immediately.
  always_comb begin
    case (speed_next)
      2'd3:    div_last = LAST_FAST;
      2'd2:    div_last = LAST_MED;
      default: div_last = LAST_SLOW;
    endcase
  end

  // Counting needs a running rate both before and after this edge: entering STOP clears at once,
  // and leaving STOP spends its first edge at zero so the first TICK lands DIV edges later.
  assign run = (speed_reg != 2'd0) && (speed_next != 2'd0);

  // Registered speed, one edge behind the debounced switches.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) speed_reg <= 2'd0;
    else         speed_reg <= speed_next;
  end

  // Divider: wrap at the current terminal count and pulse TICK for exactly one cycle.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg >= div_last) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      tick_reg    <= 1'b0;
    end
  end

  assign TICK  = tick_reg;
  assign SPEED = speed_reg;
  assign SW_DB = sw_db_w;

endmodule

// File: tb/tb_c_tick_gen.sv
// Testbench for c_tick_gen with shortened divider and debounce constants.
module tb_c_tick_gen;

  localparam int DS  = 20;
  localparam int DM  = 10;
  localparam int DF  = 4;
  localparam int DEB = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0   = 1'b0;
  logic       sw1   = 1'b0;
  logic       sw2   = 1'b0;
  logic       tick;
  logic [1:0] speed;
  logic [2:0] sw_db;

  always #5 clk = ~clk;

  c_tick_gen #(
    .DIV_SLOW  (DS),
    .DIV_MED   (DM),
    .DIV_FAST  (DF),
    .DEB_CYCLES(DEB),
    .CNT_W     (29)
  ) dut (
    .CLOCK (clk),
    .RESETN(rst_n),
    .SW0   (sw0),
    .SW1   (sw1),
    .SW2   (sw2),
    .TICK  (tick),
    .SPEED (speed),
    .SW_DB (sw_db)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Switch history: the debouncer sees the level the switch had two edges ago.
  logic [2:0] m_prev1   = 3'b000;
  logic [2:0] m_prev2   = 3'b000;
  logic [2:0] m_db      = 3'b000;
  int         m_run[3]  = '{0, 0, 0};
  int         m_speed   = 0;
  int         m_elapsed = 0;
  logic       m_tick    = 1'b0;

  function automatic int prio(input logic [2:0] d);
    if (d[2]) return 3;
    if (d[1]) return 2;
    if (d[0]) return 1;
    return 0;
  endfunction

  function automatic int period(input int s);
    case (s)
      3:       return DF;
      2:       return DM;
      1:       return DS;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_prev1 = 3'b000; m_prev2 = 3'b000; m_db = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_speed = 0; m_elapsed = 0; m_tick = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] seen;
    int         ns;
    seen    = m_prev2;
    ns      = prio(m_db);
    m_prev2 = m_prev1;
    m_prev1 = {sw2, sw1, sw0};
    for (int i = 0; i < 3; i++) begin
      if (seen[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_db[i]  = seen[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (m_speed == 0 || ns == 0) begin
      m_elapsed = 0; m_tick = 1'b0;
    end else if (m_elapsed + 1 >= period(ns)) begin
      m_elapsed = 0; m_tick = 1'b1;
    end else begin
      m_elapsed++; m_tick = 1'b0;
    end
    m_speed = ns;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_tick",  32'(tick),  32'(m_tick));
      check("cyc_speed", 32'(speed), 32'(m_speed));
      check("cyc_sw_db", 32'(sw_db), 32'(m_db));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_speed(input int s);
    for (int k = 0; k < 40; k++) begin
      if (speed == 2'(s)) break;
      edges(1);
    end
    check("wait_speed", 32'(speed), 32'(s));
  endtask

  task automatic measure_period(output int p);
    int k;
    p = -1;
    for (k = 0; k < 60; k++) begin
      edges(1);
      if (tick) break;
    end
    if (k < 60) begin
      p = 0;
      for (int j = 0; j < 60; j++) begin
        edges(1);
        p++;
        if (tick) break;
      end
    end
  endtask

  int p;

  initial begin
    // 1: held in reset with switches low
    repeat (100) begin
      @(negedge clk);
      check("t1_tick",  32'(tick),  0);
      check("t1_speed", 32'(speed), 0);
      check("t1_sw_db", 32'(sw_db), 0);
    end

    // 2: SW0 rises right after release; edges counted from release
    @(negedge clk);
    rst_n = 1'b1;
    sw0   = 1'b1;
    edges(6);  check("t2_sw_db_e6", 32'(sw_db), 32'h0);
    edges(1);  check("t2_sw_db_e7", 32'(sw_db), 32'h1);
               check("t2_speed_e7", 32'(speed), 0);
    edges(1);  check("t2_speed_e8", 32'(speed), 1);
               check("t2_tick_e8",  32'(tick),  0);
    edges(19); check("t2_tick_e27", 32'(tick),  0);
    edges(1);  check("t2_tick_e28", 32'(tick),  1);
    edges(1);  check("t2_tick_e29", 32'(tick),  0);
    edges(18); check("t2_tick_e47", 32'(tick),  0);
    edges(1);  check("t2_tick_e48", 32'(tick),  1);

    // 3: SW1 glitches 3 high / 2 low for 50 cycles
    for (int r = 0; r < 10; r++) begin
      sw1 = 1'b1; edges(3);
      sw1 = 1'b0; edges(2);
    end
    edges(4);
    check("t3_sw_db", 32'(sw_db), 32'h1);
    check("t3_speed", 32'(speed), 1);

    // 4: SW2 over SW0 gives FAST; dropping it returns to SLOW
    sw2 = 1'b1;
    wait_speed(3);
    measure_period(p); check("t4_period_fast_a", 32'(p), 4);
    measure_period(p); check("t4_period_fast_b", 32'(p), 4);
    sw2 = 1'b0;
    wait_speed(1);
    measure_period(p); check("t4_period_slow", 32'(p), 20);

    // 5: raise SW2 when the slow count stands at 5, so it is 12 when SPEED flips to FAST
    for (int k = 0; k < 60; k++) begin
      if (m_speed == 1 && m_elapsed == 5) break;
      edges(1);
    end
    check("t5_start_speed", 32'(speed), 1);
    sw2 = 1'b1;
    edges(7);  check("t5_speed_k7", 32'(speed), 1);
               check("t5_tick_k7",  32'(tick),  0);
    edges(1);  check("t5_speed_k8", 32'(speed), 3);
               check("t5_tick_k8",  32'(tick),  1);
    for (int k = 9; k <= 11; k++) begin
      edges(1); check("t5_tick_gap", 32'(tick), 0);
    end
    edges(1);  check("t5_tick_k12", 32'(tick), 1);

    // 6: MED rate, then an asynchronous reset pulse mid-count
    sw2 = 1'b0;
    sw1 = 1'b1;
    wait_speed(2);
    edges(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_tick",  32'(tick),  0);
    check("t6_async_speed", 32'(speed), 0);
    check("t6_async_sw_db", 32'(sw_db), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    edges(7);  check("t6_speed_e7", 32'(speed), 0);
    edges(1);  check("t6_speed_e8", 32'(speed), 2);
               check("t6_sw_db_e8", 32'(sw_db), 32'h3);
    edges(9);  check("t6_tick_e17", 32'(tick),  0);
    edges(1);  check("t6_tick_e18", 32'(tick),  1);
    edges(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
